lfsr_rng_bcd: RTL and testbench

- Parametrised pseudo-random number source.
- Maximal-length LFSR with configurable width and tap mask, seed load, step enable and lock-up protection.
- An iterative double-dabble converter turns a sampled slice of the state into 3-digit BCD for the seven-segment display path.
- Sits between the game/control logic (which requests numbers) and the display drivers.

---
 rtl/lfsr_rng_bcd_if.sv | 29 ++
 rtl/lfsr_rng_bcd.sv | 148 ++++++++++++++
 tb/tb_lfsr_rng_bcd.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_rng_bcd_if.sv
// lfsr_rng_bcd_if: request/seed controls and number/BCD results shared
// between the game/control logic (master) and the random source (slave).
interface lfsr_rng_bcd_if #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned OUT_BITS = 5
);
    logic                en;
    logic                load;
    logic [WIDTH-1:0]    seed_in;
    logic                req;
    logic [WIDTH-1:0]    state;
    logic [OUT_BITS-1:0] rnd;
    logic                busy;
    logic                valid;
    logic [3:0]          ones;
    logic [3:0]          tens;
    logic [3:0]          hundreds;
    logic                lockup;

    modport master (
        output en, load, seed_in, req,
        input  state, rnd, busy, valid, ones, tens, hundreds, lockup
    );

    modport slave (
        input  en, load, seed_in, req,
        output state, rnd, busy, valid, ones, tens, hundreds, lockup
    );
endinterface

// File: rtl/lfsr_rng_bcd.sv
// lfsr_rng_bcd: maximal-length LFSR with seed load and lock-up recovery,
// plus an iterative double-dabble converter producing 3-digit BCD from a
// sampled slice of the state.
// Build option: define LFSR_GALOIS_EN for the Galois right-shift LFSR form;
// the default is the Fibonacci left-shift form.
module lfsr_rng_bcd #(
    parameter int unsigned      WIDTH    = 5,
    parameter logic [WIDTH-1:0] TAPS     = 5'h14,
    parameter logic [WIDTH-1:0] SEED     = 5'h01,
    parameter int unsigned      OUT_BITS = 5
) (
    input logic           clk,
    input logic           rst,
    lfsr_rng_bcd_if.slave bus
);
    localparam int unsigned CW = $clog2(OUT_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } conv_state_e;

    logic [WIDTH-1:0]    state_q, state_d, step_val;
    logic                lockup_q, lockup_d;
    conv_state_e         cs_q, cs_d;
    logic [OUT_BITS-1:0] rnd_q, rnd_d;
    logic [OUT_BITS-1:0] sh_q, sh_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [11:0]         scr_q, scr_d, scr_adj;
    logic [3:0]          ones_q, ones_d;
    logic [3:0]          tens_q, tens_d;
    logic [3:0]          hund_q, hund_d;

`ifdef LFSR_GALOIS_EN
    // Galois step: shift right, fold taps in when the outgoing bit is 1
    always_comb step_val = {1'b0, state_q[WIDTH-1:1]} ^ (state_q[0] ? TAPS : '0);
`else
    // Fibonacci step: shift left, parity of tapped bits enters at bit 0
    always_comb step_val = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
`endif

    // LFSR next state: load > lock-up guard > step > hold
    always_comb begin
        state_d  = state_q;
        lockup_d = 1'b0;
        if (bus.load) begin
            if (bus.seed_in != '0) begin
                state_d = bus.seed_in;
            end else begin
                state_d  = SEED;
                lockup_d = 1'b1;
            end
        end else if (state_q == '0) begin
            state_d  = SEED;
            lockup_d = 1'b1;
        end else if (bus.en) begin
            state_d = step_val;
        end
    end

    // LFSR register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SEED;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lockup_q <= lockup_d;
        end
    end

    // Converter next state: capture, shift-add-3 per bit, publish
    always_comb begin
        cs_d    = cs_q;
        rnd_d   = rnd_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        scr_d   = scr_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        hund_d  = hund_q;
        scr_adj = scr_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
        unique case (cs_q)
            S_IDLE: begin
                if (bus.req) begin
                    rnd_d = state_q[OUT_BITS-1:0];
                    sh_d  = state_q[OUT_BITS-1:0];
                    scr_d = '0;
                    cnt_d = CW'(OUT_BITS);
                    cs_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                scr_d = {scr_adj[10:0], sh_q[OUT_BITS-1]};
                sh_d  = sh_q << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    // Digits are registered on the final shift so they are
                    // already visible during the DONE cycle alongside valid.
                    ones_d = scr_d[3:0];
                    tens_d = scr_d[7:4];
                    hund_d = scr_d[11:8];
                    cs_d   = S_DONE;
                end
            end
            S_DONE:  cs_d = S_IDLE;
            default: cs_d = S_IDLE;
        endcase
    end

    // Converter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q   <= S_IDLE;
            rnd_q  <= '0;
            sh_q   <= '0;
            cnt_q  <= '0;
            scr_q  <= '0;
            ones_q <= '0;
            tens_q <= '0;
            hund_q <= '0;
        end else begin
            cs_q   <= cs_d;
            rnd_q  <= rnd_d;
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            scr_q  <= scr_d;
            ones_q <= ones_d;
            tens_q <= tens_d;
            hund_q <= hund_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.lockup   = lockup_q;
    assign bus.rnd      = rnd_q;
    assign bus.busy     = (cs_q != S_IDLE);
    assign bus.valid    = (cs_q == S_DONE);
    assign bus.ones     = ones_q;
    assign bus.tens     = tens_q;
    assign bus.hundreds = hund_q;
endmodule

// File: tb/tb_lfsr_rng_bcd.sv
// tb_lfsr_rng_bcd: randomized + directed bench with a behavioural model and
// a scoreboard of captured samples checked whenever valid pulses.
module tb_lfsr_rng_bcd;
    localparam int unsigned W      = 5;
    localparam int unsigned OB     = 5;
    localparam int unsigned TAPS_I = 'h14;
    localparam int unsigned SEED_I = 'h01;

    logic clk = 1'b0;
    logic rst;
    logic rst9;
    always #5 clk = ~clk;

    lfsr_rng_bcd_if #(.WIDTH(W), .OUT_BITS(OB)) bus ();
    lfsr_rng_bcd #(.WIDTH(W), .TAPS(5'h14), .SEED(5'h01), .OUT_BITS(OB)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    lfsr_rng_bcd_if #(.WIDTH(9), .OUT_BITS(9)) bus9 ();
    lfsr_rng_bcd #(.WIDTH(9), .TAPS(9'h110), .SEED(9'h001), .OUT_BITS(9)) dut9 (
        .clk(clk), .rst(rst9), .bus(bus9)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit mon_on = 1'b0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference LFSR step from the polynomial definition, in plain arithmetic
    function automatic int unsigned model_step(input int unsigned s);
`ifdef LFSR_GALOIS_EN
        return (s / 2) ^ (((s % 2) == 1) ? TAPS_I : 0);
`else
        return ((s * 2) % (1 << W)) + ($countones(s & TAPS_I) % 2);
`endif
    endfunction

    // Behavioural model: sampled on the same edge as the DUT, inputs are
    // driven 2 time units after each edge so they are stable here.
    int unsigned m_state, m_cnt, m_rnd, m_ones, m_tens, m_hund;
    bit          m_lock;
    int unsigned exp_q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_state = SEED_I; m_cnt = 0; m_lock = 0; m_rnd = 0;
            m_ones = 0; m_tens = 0; m_hund = 0;
            exp_q.delete();
        end else begin
            if (m_cnt == 0) begin
                if (bus.req) begin
                    m_rnd = m_state % (1 << OB);
                    exp_q.push_back(m_rnd);
                    m_cnt = OB + 1;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 1) begin
                    m_ones = m_rnd % 10;
                    m_tens = (m_rnd / 10) % 10;
                    m_hund = m_rnd / 100;
                end
            end
            m_lock = 0;
            if (bus.load) begin
                if (bus.seed_in == 0) begin m_state = SEED_I; m_lock = 1; end
                else m_state = bus.seed_in;
            end else if (m_state == 0) begin
                m_state = SEED_I; m_lock = 1;
            end else if (bus.en) begin
                m_state = model_step(m_state);
            end
        end
    end

    // Monitor: per-cycle output compare, scoreboard pop on valid
    always @(negedge clk) begin
        if (mon_on) begin
            check("state", bus.state, m_state);
            check("busy", bus.busy, m_cnt != 0);
            check("valid", bus.valid, m_cnt == 1);
            check("lockup", bus.lockup, m_lock);
            check("ones_hold", bus.ones, m_ones);
            check("tens_hold", bus.tens, m_tens);
            check("hund_hold", bus.hundreds, m_hund);
            if (bus.valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_empty: valid with no pending request at %0t", $time);
                end else begin
                    automatic int unsigned v = exp_q.pop_front();
                    check("sb_rnd", bus.rnd, v);
                    check("sb_ones", bus.ones, v % 10);
                    check("sb_tens", bus.tens, (v / 10) % 10);
                    check("sb_hund", bus.hundreds, v / 100);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int unsigned exp_seq[6];
    int          k;
    int          nvalid;

    initial begin
        rst = 1'b1; rst9 = 1'b1;
        bus.en = 0; bus.load = 0; bus.seed_in = '0; bus.req = 0;
        bus9.en = 0; bus9.load = 0; bus9.seed_in = '0; bus9.req = 0;
`ifdef LFSR_GALOIS_EN
        exp_seq = '{'h01, 'h14, 'h0A, 'h05, 'h16, 'h0B};
`else
        exp_seq = '{'h01, 'h02, 'h04, 'h09, 'h12, 'h05};
`endif
        repeat (2) tick();
        rst = 1'b0; mon_on = 1'b1;

        // reset state and first steps
        @(negedge clk);
        check("rst_rnd", bus.rnd, 0);
        check("rst_busy", bus.busy, 0);
        @(posedge clk); #2;
        bus.en = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("seq", bus.state, exp_seq[i]);
            @(posedge clk); #2;
        end
        repeat (25) tick();
        bus.en = 0;
        @(negedge clk);
        check("period", bus.state, SEED_I);

        // conversion of 0x12 with an ignored second request
        @(posedge clk); #2;
        bus.load = 1; bus.seed_in = 5'h12;
        tick();
        bus.load = 0; bus.req = 1;
        tick();
        bus.req = 0;
        fork
            begin
                repeat (2) @(posedge clk);
                #2 bus.req = 1;
                @(posedge clk);
                #2 bus.req = 0;
            end
        join_none
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            @(negedge clk);
            if (bus.valid) k = i;
        end
        check("lat5", k, 6);
        check("rnd18", bus.rnd, 18);
        check("ones18", bus.ones, 8);
        check("tens18", bus.tens, 1);
        check("hund18", bus.hundreds, 0);
        repeat (10) tick();

        // zero seed recovery, then load beats step
        bus.load = 1; bus.seed_in = '0;
        tick();
        bus.load = 0;
        @(negedge clk);
        check("lock_state", bus.state, SEED_I);
        check("lock_pulse", bus.lockup, 1);
        @(posedge clk); #2;
        @(negedge clk);
        check("lock_clear", bus.lockup, 0);
        @(posedge clk); #2;
        bus.load = 1; bus.en = 1; bus.seed_in = 5'h1F;
        tick();
        bus.load = 0; bus.en = 0;
        @(negedge clk);
        check("load_wins", bus.state, 'h1F);

        // reset aborts a conversion in flight
        @(posedge clk); #2;
        bus.req = 1;
        tick();
        bus.req = 0;
        repeat (2) tick();
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_state", bus.state, SEED_I);
        check("abort_bcd", {bus.hundreds, bus.tens, bus.ones}, 0);
        nvalid = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.valid) nvalid++;
        end
        check("abort_novalid", nvalid, 0);
        @(posedge clk); #2;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.en      = 1'($urandom % 2);
            bus.load    = ($urandom % 16) == 0;
            bus.seed_in = (($urandom % 4) == 0) ? '0 : 5'($urandom);
            bus.req     = ($urandom % 4) == 0;
            rst         = ($urandom % 300) == 0;
            tick();
        end
        bus.en = 0; bus.load = 0; bus.req = 0; rst = 0;
        repeat (20) tick();
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL sb_drain: %0d results missing, required 0", exp_q.size());

        // 9-bit instance: 511 -> 5/1/1
        rst9 = 0;
        bus9.load = 1; bus9.seed_in = 9'h1FF;
        tick();
        bus9.load = 0; bus9.req = 1;
        tick();
        bus9.req = 0;
        k = 0;
        for (int i = 1; i <= 30 && k == 0; i++) begin
            @(negedge clk);
            if (bus9.valid) k = i;
        end
        check("lat9", k, 10);
        check("rnd9", bus9.rnd, 511);
        check("hund9", bus9.hundreds, 5);
        check("tens9", bus9.tens, 1);
        check("ones9", bus9.ones, 1);

        mon_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
